// File: rtl/rram_crossbar_ctrl.sv
// rtl/rram_crossbar_ctrl.sv - RRAM crossbar row write/read sequencer with ADC group sweep
// Optional RRAM_CTRL_STATS_EN adds saturating wr_count/rd_count outputs.
module rram_crossbar_ctrl #(
  parameter int ROWS       = 1024,
  parameter int COLS       = 1024,
  parameter int NUM_ADCS   = 32,
  parameter int ADC_BITS   = 4,
  parameter int SEL_W      = 4,
  parameter int WR_CYCLES  = 16,
  parameter int ADC_SETTLE = 4
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_op,
  input  logic [$clog2(ROWS)-1:0]      cmd_row,
  input  logic [COLS-1:0]              cmd_data,
  output logic [ROWS-1:0]              WL,
  output logic [COLS-1:0]              BL,
  output logic                         WREN,
  output logic                         RDEN,
  output logic [SEL_W-1:0]             ADCSEL,
  input  logic [ADC_BITS-1:0]          ADCout [NUM_ADCS],
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [NUM_ADCS*ADC_BITS-1:0] rd_data,
  output logic                         rd_last,
  output logic                         busy
`ifdef RRAM_CTRL_STATS_EN
  ,
  output logic [15:0]                  wr_count,
  output logic [15:0]                  rd_count
`endif
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] WR_LAST     = CNT_W'(WR_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(ADC_SETTLE);

  typedef enum logic [2:0] {
    IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_SETTLE, RD_OUT
  } state_t;

  state_t                       state, state_d;
  logic [CNT_W-1:0]             cnt, cnt_d;
  logic [ROWS-1:0]              wl_d, row_onehot;
  logic [COLS-1:0]              bl_d;
  logic                         wren_d, rden_d, valid_d, last_d;
  logic [SEL_W-1:0]             sel_d;
  logic [NUM_ADCS*ADC_BITS-1:0] data_d, adc_packed;
  logic                         beat_done;

  for (genvar g = 0; g < NUM_ADCS; g++) begin : g_pack
    assign adc_packed[g*ADC_BITS +: ADC_BITS] = ADCout[g];
  end

  assign row_onehot = {{(ROWS-1){1'b0}}, 1'b1} << cmd_row;
  assign cmd_ready  = (state == IDLE) && !RESET;
  assign busy       = (state != IDLE);
  assign beat_done  = rd_valid && rd_ready;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    wl_d    = WL;
    bl_d    = BL;
    wren_d  = WREN;
    rden_d  = RDEN;
    sel_d   = ADCSEL;
    valid_d = rd_valid;
    data_d  = rd_data;
    last_d  = rd_last;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          cnt_d = '0;
          wl_d  = row_onehot;
          if (cmd_op) begin
            bl_d    = '0;
            rden_d  = 1'b1;
            sel_d   = '0;
            state_d = RD_SETTLE;
          end else begin
            bl_d    = cmd_data;
            state_d = WR_SETUP;
          end
        end
      end
      WR_SETUP: begin
        wren_d  = 1'b1;
        cnt_d   = '0;
        state_d = WR_PULSE;
      end
      WR_PULSE: begin
        if (cnt == WR_LAST) begin
          wren_d  = 1'b0;
          state_d = WR_HOLD;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      WR_HOLD: begin
        wl_d    = '0;
        bl_d    = '0;
        state_d = IDLE;
      end
      RD_SETTLE: begin
        // Sample on the edge after the settle count completes.
        if (cnt == SETTLE_LAST) begin
          data_d  = adc_packed;
          valid_d = 1'b1;
          last_d  = (ADCSEL == '1);
          state_d = RD_OUT;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      RD_OUT: begin
        if (beat_done) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (rd_last) begin
            rden_d  = 1'b0;
            wl_d    = '0;
            sel_d   = '0;
            state_d = IDLE;
          end else begin
            sel_d   = ADCSEL + 1'b1;
            cnt_d   = '0;
            state_d = RD_SETTLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      cnt      <= '0;
      WL       <= '0;
      BL       <= '0;
      WREN     <= 1'b0;
      RDEN     <= 1'b0;
      ADCSEL   <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_last  <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      WL       <= wl_d;
      BL       <= bl_d;
      WREN     <= wren_d;
      RDEN     <= rden_d;
      ADCSEL   <= sel_d;
      rd_valid <= valid_d;
      rd_data  <= data_d;
      rd_last  <= last_d;
    end
  end

`ifdef RRAM_CTRL_STATS_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_count <= '0;
      rd_count <= '0;
    end else begin
      if (state == WR_HOLD && wr_count != 16'hFFFF)
        wr_count <= wr_count + 1'b1;
      if (state == RD_OUT && beat_done && rd_last && rd_count != 16'hFFFF)
        rd_count <= rd_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rram_crossbar_ctrl.sv
// tb/tb_rram_crossbar_ctrl.sv - self-checking bench for rram_crossbar_ctrl
// Table-driven commands plus hand sequences; read beats checked against a scoreboard queue.
module tb_rram_crossbar_ctrl;

  localparam int W  = 16;
  localparam int S  = 4;
  localparam int NB = 16;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          cmd_valid, cmd_op, cmd_ready;
  logic [9:0]    cmd_row;
  logic [1023:0] cmd_data;
  logic [1023:0] WL, BL;
  logic          WREN, RDEN;
  logic [3:0]    ADCSEL;
  logic [3:0]    adc [32];
  logic          rd_valid, rd_ready, rd_last, busy;
  logic [127:0]  rd_data;
`ifdef RRAM_CTRL_STATS_EN
  logic [15:0]   wr_count, rd_count;
`endif

  rram_crossbar_ctrl dut (
    .CLK(CLK), .RESET(RESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_row(cmd_row), .cmd_data(cmd_data),
    .WL(WL), .BL(BL), .WREN(WREN), .RDEN(RDEN), .ADCSEL(ADCSEL),
    .ADCout(adc),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_last(rd_last), .busy(busy)
`ifdef RRAM_CTRL_STATS_EN
    , .wr_count(wr_count), .rd_count(rd_count)
`endif
  );

  always #5 CLK = ~CLK;

  // ADC model: channel i of group g reads g+i.
  always_comb begin
    for (int i = 0; i < 32; i++) adc[i] = ADCSEL + 4'(i);
  end

  typedef struct { logic [127:0] data; logic last; } beat_t;
  typedef struct { logic op; logic [9:0] row; logic [1023:0] data; int occ; } vec_t;

  beat_t exp_q[$];
  vec_t  vecs[5];
  int    errors = 0;
  int    checks = 0;
  int    pops   = 0;

  function automatic logic [127:0] beat_data(input int j);
    logic [127:0] d = '0;
    for (int i = 0; i < 32; i++) d[i*4 +: 4] = 4'(j + i);
    return d;
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin errors++; $display("FAIL %s: got %b expected %b", nm, act, exp); end
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin errors++; $display("FAIL %s: got %0h expected %0h", nm, act, exp); end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin errors++; $display("FAIL %s: got %0d expected %0d", nm, act, exp); end
  endtask

  task automatic chk_w(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got ones=%0d low=%h expected ones=%0d low=%h",
               nm, $countones(act), act[63:0], $countones(exp), exp[63:0]);
    end
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  // Called just after a posedge; returns after the accept edge and how many negedges it waited.
  task automatic issue(input logic op, input logic [9:0] row, input logic [1023:0] data, output int waited);
    cmd_valid = 1'b1; cmd_op = op; cmd_row = row; cmd_data = data;
    waited = 1;
    @(negedge CLK);
    while (!cmd_ready && waited < 1000) begin @(negedge CLK); waited++; end
    if (!cmd_ready) begin errors++; checks++; $display("FAIL issue_timeout: got cmd_ready=0 expected 1"); end
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
    if (op) for (int j = 0; j < NB; j++) exp_q.push_back('{beat_data(j), j == NB - 1});
  endtask

  task automatic wait_idle(input string nm);
    int g = 0;
    while (!cmd_ready && g < 1000) begin @(negedge CLK); g++; end
    chk1(nm, cmd_ready, 1'b1);
  endtask

  always @(negedge CLK) begin
    if (!RESET) begin
      checks += 3;
      if (WREN && RDEN) begin errors++; $display("FAIL wren_rden_overlap: got both 1 expected not both"); end
      if ($countones(WL) > 1) begin errors++; $display("FAIL wl_onehot: got %0d bits expected <=1", $countones(WL)); end
      if (busy !== !cmd_ready) begin errors++; $display("FAIL busy: got %b expected %b", busy, !cmd_ready); end
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: got beat sel=%0d expected none", ADCSEL);
        end else begin
          beat_t b;
          b = exp_q.pop_front();
          chk("beat_data", rd_data, b.data);
          chk1("beat_last", rd_last, b.last);
          pops++;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int w, n, beat, p0, g;
    logic [1023:0] one;
    one = 1024'(1);
    RESET = 1'b1; cmd_valid = 1'b1; cmd_op = 1'b0; cmd_row = 10'd7; cmd_data = '1; rd_ready = 1'b1;

    repeat (5) begin
      @(negedge CLK);
      chk_w("rst_wl", WL, '0);
      chk_w("rst_bl", BL, '0);
      chk1("rst_wren", WREN, 1'b0);
      chk1("rst_rden", RDEN, 1'b0);
      chk1("rst_valid", rd_valid, 1'b0);
      chk1("rst_last", rd_last, 1'b0);
      chk1("rst_ready", cmd_ready, 1'b0);
      chk("rst_sel", 128'(ADCSEL), '0);
      chk("rst_data", rd_data, '0);
    end
    tick(); RESET = 1'b0; cmd_valid = 1'b0;
    @(negedge CLK);
    chk1("ready_after_rst", cmd_ready, 1'b1);

    // Write row 5, all ones: cycle-accurate WL/BL/WREN profile.
    tick();
    issue(1'b0, 10'd5, '1, w);
    for (n = 1; n <= W + 3; n++) begin
      @(negedge CLK);
      chk_w("wr5_wl", WL, (n <= W + 2) ? (one << 5) : '0);
      chk_w("wr5_bl", BL, (n <= W + 2) ? '1 : '0);
      chk1("wr5_wren", WREN, (n >= 2 && n <= W + 1));
    end
    chk1("wr5_idle", cmd_ready, 1'b1);

    // Command table: WL/BL/RDEN on the first cycle, then total occupancy.
    vecs[0] = '{op: 1'b0, row: 10'd0,   data: '0,                          occ: W + 3};
    vecs[1] = '{op: 1'b0, row: 10'd777, data: {32{32'hA5C3_0F96}},         occ: W + 3};
    vecs[2] = '{op: 1'b1, row: 10'd3,   data: '1,                          occ: NB * (S + 2) + 1};
    vecs[3] = '{op: 1'b0, row: 10'd1023,data: {16{64'h0123_4567_89AB_CDEF}}, occ: W + 3};
    vecs[4] = '{op: 1'b1, row: 10'd512, data: '0,                          occ: NB * (S + 2) + 1};
    for (int v = 0; v < 5; v++) begin
      tick();
      issue(vecs[v].op, vecs[v].row, vecs[v].data, w);
      n = 1;
      @(negedge CLK);
      chk_w("vec_wl", WL, one << vecs[v].row);
      chk_w("vec_bl", BL, vecs[v].op ? '0 : vecs[v].data);
      chk1("vec_rden", RDEN, vecs[v].op);
      while (!cmd_ready && n < 1000) begin @(negedge CLK); n++; end
      chk_i("vec_occupancy", n, vecs[v].occ);
    end
    chk_i("vec_queue_empty", exp_q.size(), 0);

    // Read row 1023 with rd_ready high: beat timing.
    tick();
    issue(1'b1, 10'd1023, '0, w);
    beat = 0;
    for (n = 1; n <= NB * (S + 2) + 1; n++) begin
      @(negedge CLK);
      if (n == 1) begin
        chk_w("rd_wl", WL, one << 1023);
        chk1("rd_rden", RDEN, 1'b1);
        chk("rd_sel0", 128'(ADCSEL), '0);
      end
      if (rd_valid) begin
        chk_i("beat_time", n, (S + 2) * (beat + 1));
        beat++;
      end
    end
    chk1("rd_idle", cmd_ready, 1'b1);
    chk_i("rd_beats", beat, NB);

    // Stall rd_ready for 10 cycles on beat 3.
    tick();
    issue(1'b1, 10'd10, '0, w);
    p0 = pops;
    g = 0;
    while (!(rd_valid && pops == p0 + 3) && g < 400) begin tick(); g++; end
    chk1("stall_reach_beat3", rd_valid, 1'b1);
    rd_ready = 1'b0;
    repeat (10) begin
      @(negedge CLK);
      chk1("stall_valid", rd_valid, 1'b1);
      chk("stall_data", rd_data, beat_data(3));
      chk("stall_sel", 128'(ADCSEL), 128'(3));
      chk1("stall_rden", RDEN, 1'b1);
      tick();
    end
    rd_ready = 1'b1;
    wait_idle("stall_done");
    chk_i("stall_beats", pops - p0, NB);
    chk_i("stall_queue_empty", exp_q.size(), 0);

    // Reset during WR_PULSE.
    tick();
    issue(1'b0, 10'd100, '1, w);
    repeat (4) tick();
    chk1("pulse_before_rst", WREN, 1'b1);
    RESET = 1'b1;
    tick();
    @(negedge CLK);
    chk1("rst_pulse_wren", WREN, 1'b0);
    chk_w("rst_pulse_wl", WL, '0);
    tick(); RESET = 1'b0;

    // Reset during RD_OUT.
    rd_ready = 1'b0;
    issue(1'b1, 10'd200, '0, w);
    g = 0;
    while (!rd_valid && g < 400) begin tick(); g++; end
    chk1("rdout_reached", rd_valid, 1'b1);
    RESET = 1'b1;
    tick();
    @(negedge CLK);
    chk1("rst_rd_rden", RDEN, 1'b0);
    chk1("rst_rd_valid", rd_valid, 1'b0);
    chk_w("rst_rd_wl", WL, '0);
    exp_q.delete();
    tick(); RESET = 1'b0; rd_ready = 1'b1;

    // Following write to row 0 completes normally.
    issue(1'b0, 10'd0, {32{32'h5A5A_F00F}}, w);
    n = 1;
    @(negedge CLK);
    chk_w("post_rst_wl", WL, one);
    while (!cmd_ready && n < 1000) begin @(negedge CLK); n++; end
    chk_i("post_rst_occupancy", n, W + 3);

    // Back-to-back write then read with cmd_valid held, from a fresh reset.
    tick(); RESET = 1'b1;
    tick(); RESET = 1'b0;
    issue(1'b0, 10'd33, '1, w);
    issue(1'b1, 10'd34, '0, w);
    chk_i("b2b_accept_wait", w, W + 3);
    wait_idle("b2b_done");
    chk_i("b2b_queue_empty", exp_q.size(), 0);
`ifdef RRAM_CTRL_STATS_EN
    chk("wr_count", 128'(wr_count), 128'(1));
    chk("rd_count", 128'(rd_count), 128'(1));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
